// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Fetch-stage front end. Owns the architectural fetch PC, issues requests on
//   the instruction bus, and presents fetched instructions to the IF/ID
//   register. A one-entry buffer absorbs a response that arrives while IF/ID is
//   stalled. A redirect that lands while a request is outstanding is parked in
//   pending_pc until the bus completes; the stale response is then dropped.
//
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   pcplus4             pc + 4, to pcselect
//   pc_selected         next PC chosen by pcselect
//   redirect            branch taken in EX (flushes the fetch stage)
//   stall               IF/ID not ready; if_* hold
//   ireq_valid/addr     instruction request
//   iresp_data_ok/data  instruction response (completes the current request)
//   if_valid/pc/instr   instruction presented to IF/ID
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          INSN_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [63:0]       pcplus4,
    input  logic [63:0]       pc_selected,
    input  logic              redirect,
    input  logic              stall,
    output logic              ireq_valid,
    output logic [63:0]       ireq_addr,
    input  logic              iresp_data_ok,
    input  logic [INSN_W-1:0] iresp_data,
    output logic              if_valid,
    output logic [63:0]       if_pc,
    output logic [INSN_W-1:0] if_instr
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t             state;
    logic [63:0]        pc;
    logic [63:0]        pending_pc;
    logic [63:0]        buf_pc;
    logic [INSN_W-1:0]  buf_instr;
    logic               out_ready;

    assign pcplus4    = pc + 64'd4;
    // In DRAIN the address stays on the old pc so the bus sees a stable request.
    assign ireq_addr  = pc;
    // Combinational in reset so the request drops the instant reset rises.
    assign ireq_valid = !reset && (state != HOLD);
    // The output register can take a new instruction when empty or being accepted.
    assign out_ready  = !if_valid || !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pending_pc <= '0;
            buf_pc     <= '0;
            buf_instr  <= '0;
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_instr   <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        if (iresp_data_ok) begin
                            // Response belongs to the wrong path: drop it.
                            pc <= pc_selected;
                        end else begin
                            pending_pc <= pc_selected;
                            state      <= DRAIN;
                        end
                    end else if (iresp_data_ok) begin
                        pc <= pc_selected;
                        if (out_ready) begin
                            if_valid <= 1'b1;
                            if_pc    <= pc;
                            if_instr <= iresp_data;
                        end else begin
                            buf_pc    <= pc;
                            buf_instr <= iresp_data;
                            state     <= HOLD;
                        end
                    end else if (if_valid && !stall) begin
                        if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        // Buffered instruction is wrong-path; restart at the target.
                        if_valid <= 1'b0;
                        pc       <= pc_selected;
                        state    <= FETCH;
                    end else if (!stall) begin
                        if_valid <= 1'b1;
                        if_pc    <= buf_pc;
                        if_instr <= buf_instr;
                        state    <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                    end
                    if (iresp_data_ok) begin
                        // Youngest redirect wins, including one arriving this cycle.
                        pc    <= redirect ? pc_selected : pending_pc;
                        state <= FETCH;
                    end else if (redirect) begin
                        pending_pc <= pc_selected;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed cycle-by-cycle stimulus with a
// scoreboard queue of expected presented instructions and a monitor that pops
// and compares every instruction accepted by IF/ID.
module tb_pc_fetch_unit;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [63:0] br_target;
    logic        data_ok;

    logic [63:0] pcplus4, pc_selected, ireq_addr, if_pc;
    logic        ireq_valid, if_valid;
    logic [31:0] iresp_data, if_instr;

    // Second instance checks the 2^64 wrap of the PC.
    logic [63:0] w_pcplus4, w_ireq_addr, w_if_pc;
    logic        w_ireq_valid, w_if_valid, w_ok, w_redirect, w_stall;
    logic [31:0] w_iresp_data, w_if_instr;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    always #5 clk = ~clk;

    // pcselect and ibus models
    assign pc_selected  = redirect ? br_target : pcplus4;
    assign iresp_data   = ireq_addr[31:0] ^ KEY;
    assign w_iresp_data = w_ireq_addr[31:0] ^ KEY;

    pc_fetch_unit u_dut (
        .clk(clk), .reset(reset), .pcplus4(pcplus4), .pc_selected(pc_selected),
        .redirect(redirect), .stall(stall), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(data_ok), .iresp_data(iresp_data),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    pc_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .pcplus4(w_pcplus4), .pc_selected(w_pcplus4),
        .redirect(w_redirect), .stall(w_stall), .ireq_valid(w_ireq_valid), .ireq_addr(w_ireq_addr),
        .iresp_data_ok(w_ok), .iresp_data(w_iresp_data),
        .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instr(w_if_instr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic set(input logic ok, input logic st, input logic rd, input logic [63:0] tgt);
        data_ok   = ok;
        stall     = st;
        redirect  = rd;
        br_target = tgt;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: an instruction is consumed when presented, not stalled and not flushed.
    always @(negedge clk) begin
        if (!reset && if_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_insn act=%h exp=none", if_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("mon_pc", if_pc, mon_exp);
                chk("mon_instr", {32'd0, if_instr}, {32'd0, mon_exp[31:0] ^ KEY});
            end
        end
    end

    initial begin
        reset = 1'b1; w_ok = 1'b1; w_redirect = 1'b0; w_stall = 1'b0;
        set(0, 0, 0, 64'd0);
        next(); next();
        @(negedge clk);
        chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        chk("rst_if_pc", if_pc, 64'd0);
        chk("rst_if_instr", {32'd0, if_instr}, 64'd0);
        chk("rst_w_ireq_valid", {63'd0, w_ireq_valid}, 64'd0);
        next();
        reset = 1'b0;

        // Streaming at one instruction per cycle
        set(1, 0, 0, 0); exp_q.push_back(64'h8000_0000);
        @(negedge clk);
        chk("A_ireq_valid", {63'd0, ireq_valid}, 64'd1);
        chk("A_addr", ireq_addr, 64'h8000_0000);
        chk("A_if_valid", {63'd0, if_valid}, 64'd0);
        chk("A_pcplus4", pcplus4, 64'h8000_0004);
        chk("wrap_pcplus4", w_pcplus4, 64'd0);
        chk("wrap_addr0", w_ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        next();
        exp_q.push_back(64'h8000_0004);
        @(negedge clk);
        chk("B_addr", ireq_addr, 64'h8000_0004);
        chk("B_if_valid", {63'd0, if_valid}, 64'd1);
        chk("wrap_addr1", w_ireq_addr, 64'd0);
        next();
        exp_q.push_back(64'h8000_0008);
        @(negedge clk); chk("C_addr", ireq_addr, 64'h8000_0008);
        next();

        // Stall with a response arriving: buffered, bus idle, then drains
        set(1, 1, 0, 0); exp_q.push_back(64'h8000_000C);
        @(negedge clk);
        chk("D_addr", ireq_addr, 64'h8000_000C);
        chk("D_if_pc", if_pc, 64'h8000_0008);
        next();
        set(0, 1, 0, 0);
        @(negedge clk);
        chk("E_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        chk("E_if_pc", if_pc, 64'h8000_0008);
        chk("E_if_valid", {63'd0, if_valid}, 64'd1);
        next();
        @(negedge clk);
        chk("F_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        chk("F_if_instr", {32'd0, if_instr}, {32'd0, 32'h8000_0008 ^ KEY});
        next();
        set(0, 0, 0, 0);
        @(negedge clk);
        chk("G_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        next();
        @(negedge clk);
        chk("H_if_pc", if_pc, 64'h8000_000C);
        chk("H_ireq_valid", {63'd0, ireq_valid}, 64'd1);
        chk("H_addr", ireq_addr, 64'h8000_0010);
        next();

        // Redirect while a request is outstanding
        set(0, 0, 1, 64'h8000_0100);
        @(negedge clk); chk("I_if_valid", {63'd0, if_valid}, 64'd0);
        next();
        set(0, 0, 0, 0);
        @(negedge clk);
        chk("J_addr", ireq_addr, 64'h8000_0010);
        chk("J_ireq_valid", {63'd0, ireq_valid}, 64'd1);
        chk("J_if_valid", {63'd0, if_valid}, 64'd0);
        next();
        set(1, 0, 0, 0);
        @(negedge clk); chk("K_addr", ireq_addr, 64'h8000_0010);
        next();
        exp_q.push_back(64'h8000_0100);
        @(negedge clk);
        chk("L_addr", ireq_addr, 64'h8000_0100);
        chk("L_if_valid", {63'd0, if_valid}, 64'd0);
        next();
        set(0, 0, 0, 0);
        @(negedge clk); chk("M_addr", ireq_addr, 64'h8000_0104);
        next();

        // Two redirects inside one drain: youngest wins
        set(0, 0, 1, 64'h8000_0200);
        @(negedge clk); chk("N_if_valid", {63'd0, if_valid}, 64'd0);
        next();
        set(0, 0, 1, 64'h8000_0300);
        @(negedge clk); chk("O_addr", ireq_addr, 64'h8000_0104);
        next();
        set(1, 0, 0, 0);
        @(negedge clk); chk("P_addr", ireq_addr, 64'h8000_0104);
        next();
        exp_q.push_back(64'h8000_0300);
        @(negedge clk);
        chk("Q_addr", ireq_addr, 64'h8000_0300);
        chk("Q_if_valid", {63'd0, if_valid}, 64'd0);
        next();
        set(0, 0, 0, 0);
        @(negedge clk); chk("R_addr", ireq_addr, 64'h8000_0304);
        next();

        // Redirect coinciding with data_ok drops the response
        set(1, 0, 1, 64'h8000_0400);
        @(negedge clk); chk("S_addr", ireq_addr, 64'h8000_0304);
        next();
        set(1, 0, 0, 0);
        @(negedge clk);
        chk("T_addr", ireq_addr, 64'h8000_0400);
        chk("T_if_valid", {63'd0, if_valid}, 64'd0);
        next();

        // Redirect beats stall while holding a buffered instruction
        set(1, 1, 0, 0);
        @(negedge clk);
        chk("U_if_pc", if_pc, 64'h8000_0400);
        chk("U_if_valid", {63'd0, if_valid}, 64'd1);
        next();
        set(0, 1, 1, 64'h8000_0500);
        @(negedge clk); chk("V_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        next();
        set(0, 0, 1, 64'h8000_0600);
        @(negedge clk);
        chk("W_if_valid", {63'd0, if_valid}, 64'd0);
        chk("W_addr", ireq_addr, 64'h8000_0500);
        next();

        // Reset while in DRAIN
        set(0, 0, 0, 0);
        reset = 1'b1; exp_q.delete();
        #1;
        chk("X_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        chk("X_if_valid", {63'd0, if_valid}, 64'd0);
        next();
        reset = 1'b0;
        set(1, 0, 0, 0); exp_q.push_back(64'h8000_0000);
        @(negedge clk); chk("Y_addr", ireq_addr, 64'h8000_0000);
        next();

        // Reset while in HOLD
        set(1, 1, 0, 0);
        @(negedge clk); chk("Z_if_pc", if_pc, 64'h8000_0000);
        next();
        set(0, 1, 0, 0);
        @(negedge clk);
        chk("AA_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        reset = 1'b1; exp_q.delete();
        #1;
        chk("AA_rst_if_valid", {63'd0, if_valid}, 64'd0);
        chk("AA_rst_if_pc", if_pc, 64'd0);
        chk("AA_rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        next();
        reset = 1'b0;
        set(1, 0, 0, 0); exp_q.push_back(64'h8000_0000);
        @(negedge clk); chk("AB_addr", ireq_addr, 64'h8000_0000);
        next();
        set(0, 0, 0, 0);
        @(negedge clk); chk("AC_if_pc", if_pc, 64'h8000_0000);
        next();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
